// File: rtl/rs_encoder_param.sv
// Systematic Reed-Solomon encoder over GF(2^M) with valid/ready streams on both sides.
// Data symbols pass through; NPAR parity symbols follow, highest degree first.
module rs_encoder_param #(
    parameter int unsigned M    = 8,
    parameter logic [M:0]  PRIM = 9'h11D,
    parameter int unsigned NPAR = 6,
    parameter int unsigned FCR  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [M-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [M-1:0] m_data,
    output logic         m_parity,
    output logic         m_last,
    output logic         busy,
    output logic         err_len
);

    localparam int unsigned KMAX = (1 << M) - 1 - NPAR;
    localparam logic [M-1:0] KMAX_W = M'(KMAX);
    localparam int unsigned PW = (NPAR > 1) ? $clog2(NPAR) : 1;
    localparam logic [PW-1:0] PLAST = PW'(NPAR - 1);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < M; i++) begin
            if (b[i]) p = p ^ aa;
            if (aa[M-1]) aa = (aa << 1) ^ PRIM[M-1:0];
            else         aa = aa << 1;
        end
        return p;
    endfunction

    // Expands prod (x + alpha^(FCR+i)); the monic top coefficient is dropped.
    function automatic logic [NPAR-1:0][M-1:0] gen_poly();
        logic [NPAR:0][M-1:0] g;
        logic [M-1:0]         root;
        g    = '0;
        g[0] = M'(1);
        root = M'(1);
        for (int unsigned i = 0; i < FCR; i++) root = gf_mul(root, M'(2));
        for (int unsigned i = 0; i < NPAR; i++) begin
            for (int unsigned j = NPAR; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, M'(2));
        end
        return g[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][M-1:0] G = gen_poly();

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

    state_t                state_q, state_d;
    logic [NPAR-1:0][M-1:0] r_q, r_d, r_upd, r_shift;
    logic [M-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [M-1:0]          o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_par_q, o_par_d;
    logic                  o_last_q, o_last_d;
    logic                  err_q, err_d;
    logic                  slot, xfer;
    logic [M-1:0]          fb;

    always_comb begin
        slot    = !o_valid_q || m_ready;
        s_ready = slot && (state_q != S_PARITY);
        xfer    = s_valid && s_ready;
        cnt_inc = cnt_q + 1'b1;

        fb       = r_q[NPAR-1] ^ s_data;
        r_upd[0] = gf_mul(fb, G[0]);
        r_shift[0] = '0;
        for (int unsigned i = 1; i < NPAR; i++) begin
            r_upd[i]   = r_q[i-1] ^ gf_mul(fb, G[i]);
            r_shift[i] = r_q[i-1];
        end

        state_d   = state_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        o_par_d   = o_par_q;
        o_last_d  = o_last_q;
        err_d     = err_q;

        // A free slot with nothing new to load means the held symbol was consumed.
        if (slot) o_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    o_data_d  = s_data;
                    o_valid_d = 1'b1;
                    o_par_d   = 1'b0;
                    o_last_d  = 1'b0;
                    r_d       = r_upd;
                    cnt_d     = M'(1);
                    if (s_last) begin
                        state_d = S_PARITY;
                    end else if (KMAX_W == M'(1)) begin
                        state_d = S_PARITY;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    o_data_d  = s_data;
                    o_valid_d = 1'b1;
                    o_par_d   = 1'b0;
                    o_last_d  = 1'b0;
                    r_d       = r_upd;
                    cnt_d     = cnt_inc;
                    if (s_last) begin
                        state_d = S_PARITY;
                    end else if (cnt_inc == KMAX_W) begin
                        state_d = S_PARITY;
                        err_d   = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (slot) begin
                    o_data_d  = r_q[NPAR-1];
                    o_valid_d = 1'b1;
                    o_par_d   = 1'b1;
                    o_last_d  = 1'b0;
                    r_d       = r_shift;
                    pcnt_d    = pcnt_q + 1'b1;
                    if (pcnt_q == PLAST) begin
                        o_last_d = 1'b1;
                        r_d      = '0;
                        cnt_d    = '0;
                        pcnt_d   = '0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_par_q   <= 1'b0;
            o_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_par_q   <= o_par_d;
            o_last_q  <= o_last_d;
            err_q     <= err_d;
        end
    end

    assign m_valid  = o_valid_q;
    assign m_data   = o_data_q;
    assign m_parity = o_par_q;
    assign m_last   = o_last_q;
    assign busy     = (state_q != S_IDLE);
    assign err_len  = err_q;

endmodule

// File: doc/rs_encoder_param.md
# rs_encoder_param

Parametrised systematic Reed-Solomon encoder over GF(2^M): accepts a message of up to 2^M-1-NPAR symbols on a valid/ready stream, passes the data symbols through unchanged, then appends NPAR parity symbols. It is the configurable successor to the fixed RS(255,249) encoder in the channel-coding path. It adds runtime message length (shortened codes), backpressure on both sides, a length-overflow flag and a single posedge clock domain.

## Interface
- M, 8, symbol width in bits; the field is GF(2^M).
- PRIM, 9'h11D, primitive polynomial including the x^M term.
- NPAR, 6, parity symbols per block (2..16). Corrects NPAR/2 symbol errors.
- FCR, 1, first consecutive root. g(x)=prod_{i=0..NPAR-1}(x+alpha^(FCR+i)), with alpha=2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  encoder accepts the input symbol this cycle.
- s_data  in  M  message symbol. The first symbol is the highest-degree coefficient.
- s_last  in  1  marks the final message symbol.
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts the output symbol.
- m_data  out  M  codeword symbol.
- m_parity  out  1  the current m_data is a parity symbol.
- m_last  out  1  the current m_data is the final parity symbol of the block.
- busy  out  1  a block is in progress (state is not IDLE).
- err_len  out  1  sticky flag: a message overran KMAX=2^M-1-NPAR symbols. Cleared only by rst.

## Operation
- The generator coefficients g0..g(NPAR-1) are constants computed at elaboration from M, PRIM, NPAR and FCR. For M=8, NPAR=6, FCR=1 the coefficients are g0..g5 = 117,49,58,158,4,126 (monic).
- The remainder register R[0..NPAR-1] is NPAR symbols, each M bits.
- On each data transfer, with f = R[NPAR-1]^s_data:
  - R[0] <= f*g0.
  - R[i] <= R[i-1] ^ f*g[i] for i = 1..NPAR-1.
  - GF multiply is constant-coefficient polynomial multiply reduced mod PRIM.
  - All additions are XOR. No widths grow; every value is M bits.
- Output is held in a single register stage (O, m_valid). Define slot = !m_valid || m_ready.
- s_ready = slot && state!=PARITY.
- State IDLE:
  - A transfer loads O with s_data (m_parity=0, m_last=0), updates R and sets the data count cnt to 1.
  - Go to DATA, or go straight to PARITY if s_last is set (a 1-symbol message is legal).
- State DATA:
  - Each transfer loads O, updates R and increments cnt.
  - Go to PARITY on a transfer with s_last=1.
  - Also go to PARITY when cnt reaches KMAX without s_last. In that case set err_len, and treat the next input symbol as the start of a new block.
- State PARITY:
  - Each cycle with slot=1: O <= R[NPAR-1], m_parity=1, shift R[i] <= R[i-1], R[0] <= 0, and increment pcnt.
  - When loading the last parity symbol (pcnt==NPAR-1), set m_last=1, clear R, cnt and pcnt, and go to IDLE.
- Parity is emitted highest degree first.
- s_last on a symbol that is not transferred is ignored.

## Timing
- Reset values (on any cycle with rst=1, including mid-block; the partial block is discarded, no parity is emitted):
  - state=IDLE.
  - R=0, cnt=0, pcnt=0.
  - m_valid=0, m_data=0, m_parity=0, m_last=0.
  - busy=0, err_len=0.
  - s_ready=1 on the first cycle after reset.
- Latency: a symbol transferred at edge t appears on m_data after edge t. O is held stable while m_valid && !m_ready.
- The first parity symbol is loaded at the first slot after the s_last transfer. With m_ready held high that is the next edge.
- Throughput with m_ready=1 and s_valid=1: K+NPAR cycles per block, with s_ready low for exactly NPAR cycles. The first symbol of the next block is accepted the cycle after the last parity symbol is loaded.
- Backpressure: when m_ready=0 and m_valid=1, s_ready=0 and PARITY does not advance. R is unchanged.
- busy is high from the edge after the first data transfer through the edge that loads the last parity symbol.

## Test plan
- M=8, NPAR=6, FCR=1, K=249 all-zero message, m_ready=1 -> 249 zeros, then 6 zero parity symbols; m_last on output 255; err_len=0.
- K=1 message {0x01} -> m_data 0x01, then parity 126,4,158,58,49,117; the last one has m_parity=1 and m_last=1.
- K=3 message {0x00,0x00,0x01} sent twice back-to-back -> two identical 9-symbol codewords. s_ready is low for exactly 6 cycles between the blocks, with no gap cycle.
- Same K=3 message with m_ready toggling pseudo-randomly -> the symbol sequence is identical to the previous test. No symbol changes while m_valid && !m_ready.
- 250 symbols with no s_last -> err_len=1 after symbol 249; 6 parity symbols follow; symbol 250 starts a new block.
- rst asserted after the 10th data symbol -> the next cycle has m_valid=0 and busy=0. A following K=1 {0x01} message yields the exact parity of the K=1 test.
